dmem_ctrl: RTL
==============

# dmem_ctrl

Data-memory controller between the core and the single-port, word-wide, registered-read data memory. It arbitrates round-robin between two requesters: port 0, the core load/store path, and port 1, the debug/loader path. It converts byte, half and word accesses into word-memory operations, using a read-modify-write sequence for sub-word stores. It also performs lane extraction and sign extension for loads, and rejects misaligned accesses.

## Interface
Parameters:
- DATA_WIDTH, 32, data and byte-address width
- MEM_DEPTH, 256, memory words; index width is $clog2(MEM_DEPTH)

Ports (index p ∈ {0,1}; each port signal is a 2-entry array):
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  reset, synchronous and active-high
- req_valid[p]  in  1  request present
- req_ready[p]  out  1  request accepted this cycle
- req_we[p]  in  1  1 = store, 0 = load
- req_size[p]  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal and treated as misaligned
- req_unsigned[p]  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr[p]  in  DATA_WIDTH  byte address
- req_wdata[p]  in  DATA_WIDTH  store data, taken from the low bits
- resp_valid[p]  out  1  one-cycle response pulse
- resp_err[p]  out  1  misaligned or illegal size; qualified by resp_valid
- resp_rdata[p]  out  DATA_WIDTH  load result; 0 for stores and errors
- mem_wen  out  1  memory write enable
- mem_addr  out  DATA_WIDTH  word index = req_addr[$clog2(MEM_DEPTH)+1:2], zero-extended
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after the address is presented with mem_wen=0

## Operation
- FSM states: IDLE, LOAD, RMW, ACK. Latched request fields: port id, we, size, unsigned, addr, wdata.
- IDLE:
  - Winner = round-robin among valid ports; the port not granted last has priority.
  - last_grant resets to 1, so port 0 wins the first contest.
  - req_ready = 1 only for the winner. Accepting latches the request and updates last_grant.
- Misaligned test: half with addr[0]=1, word with addr[1:0]≠0, or size 11 → no memory access, next state ACK with err.
- Aligned load: drive mem_addr with mem_wen=0 → LOAD.
- Aligned word store: drive mem_wen=1, mem_addr, mem_wdata=req_wdata in the accept cycle → ACK.
- Aligned byte/half store: drive the read address → RMW.
- LOAD: extract the lane from mem_rdata, little-endian (byte lane addr[1:0], half lane addr[1]), extend per unsigned, pulse resp_valid → IDLE.
- RMW: merge the store data into the mem_rdata lane, drive mem_wen=1 at the latched word index, pulse resp_valid (err=0) → IDLE.
- ACK: pulse resp_valid with err as latched, rdata=0 → IDLE.
- Requests are accepted only in IDLE. Requesters hold all req fields stable while valid && !ready. Responses have no backpressure.

## Timing
- Every accepted request: accepted in cycle T, resp_valid in T+1, next acceptance no earlier than T+2 (one access per 2 cycles).
- Stores are committed to memory at the end of cycle T (word) or T+1 (sub-word); a following load always sees them.
- Reset values: req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_wen=0, mem_addr=0, mem_wdata=0; state=IDLE, last_grant=1.
- Reset mid-operation: abandon the access; no resp_valid. mem_wen is gated low in any cycle rst=1, so an RMW never half-commits.
- Simultaneous valid on both ports: exactly one ready. The loser keeps valid and wins the next IDLE contest.
- Address bits above the index range are ignored; the index wraps modulo MEM_DEPTH.

## Structure
- Package dmem_pkg: size enum (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, NUM_PORTS=2.
- Sub-module dmem_align (combinational), instantiated once: load extract/extend and store lane merge from (size, addr[1:0], unsigned).
- dmem_ctrl holds the FSM, arbiter and request latch.

## Test plan
- Port 0 word store 0xDEADBEEF @0x10, then load word @0x10 → mem_wen in the accept cycle only; load resp_rdata=0xDEADBEEF one cycle after accept.
- Byte store 0x7F @0x13 over 0x11223344, then signed load byte @0x13 → word reads 0x7F223344. Then byte store 0x80 @0x12 → signed load byte @0x12 = 0xFFFFFF80, unsigned load = 0x00000080.
- Half load @0x11 and word store @0x12 → resp_err=1, resp_rdata=0, mem_wen never asserted, memory unchanged.
- Both ports valid every cycle for 8 requests → grants alternate 0,1,0,1…, first grant port 0, each resp_valid only on the granted port one cycle after its ready.
- rst asserted during the RMW cycle of a byte store @0x20 over 0xAAAAAAAA → mem_wen stays 0, no resp_valid, a later load returns 0xAAAAAAAA.
- Port 1 holds valid with changing-idle port 0 → port 1 ready within 2 cycles; unaccepted fields held stable are consumed exactly once.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller.
package dmem_pkg;

  localparam int unsigned NUM_PORTS = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RMW  = 2'b10,
    ST_ACK  = 2'b11
  } state_e;

  // Half needs addr[0]=0, word needs addr[1:0]=0, size 11 is never legal.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Little-endian lane handling: load extract/extend and store merge.
module dmem_align
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [1:0]            i_size,
  input  logic [1:0]            i_addr_lo,
  input  logic                  i_unsigned,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_load_data,
  output logic [DATA_WIDTH-1:0] o_store_data
);

  logic [4:0]            w_shift;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [15:0]           w_lane;

  // Select lane position, then extend on load and merge on store.
  always_comb begin
    w_shift     = 5'd0;
    w_mask      = '1;
    w_lane      = 16'(i_rdata >> w_shift);
    o_load_data = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        w_shift     = {i_addr_lo, 3'b000};
        w_mask      = DATA_WIDTH'(8'hFF) << w_shift;
        w_lane      = 16'(i_rdata >> w_shift);
        o_load_data = {{(DATA_WIDTH-8){~i_unsigned & w_lane[7]}}, w_lane[7:0]};
      end
      SZ_HALF: begin
        w_shift     = {i_addr_lo[1], 4'b0000};
        w_mask      = DATA_WIDTH'(16'hFFFF) << w_shift;
        w_lane      = 16'(i_rdata >> w_shift);
        o_load_data = {{(DATA_WIDTH-16){~i_unsigned & w_lane[15]}}, w_lane};
      end
      default: begin
        o_load_data = i_rdata;
      end
    endcase
    o_store_data = (i_rdata & ~w_mask) | ((i_wdata << w_shift) & w_mask);
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Two-port round-robin data-memory controller with sub-word RMW stores.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid    [NUM_PORTS],
  output logic                  req_ready    [NUM_PORTS],
  input  logic                  req_we       [NUM_PORTS],
  input  logic [1:0]            req_size     [NUM_PORTS],
  input  logic                  req_unsigned [NUM_PORTS],
  input  logic [DATA_WIDTH-1:0] req_addr     [NUM_PORTS],
  input  logic [DATA_WIDTH-1:0] req_wdata    [NUM_PORTS],
  output logic                  resp_valid   [NUM_PORTS],
  output logic                  resp_err     [NUM_PORTS],
  output logic [DATA_WIDTH-1:0] resp_rdata   [NUM_PORTS],
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned LA_W  = IDX_W + 2;

  state_e                r_state;
  logic                  r_last_grant;
  logic                  r_port;
  logic                  r_err;
  logic                  r_unsigned;
  logic [1:0]            r_size;
  logic [LA_W-1:0]       r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_any;
  logic                  w_win;
  logic                  w_accept;
  logic                  w_misal;
  logic                  w_we;
  logic [1:0]            w_size;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [DATA_WIDTH-1:0] w_store_data;
  logic                  w_unused;

  // Address bits above the word index are don't-care.
  assign w_unused = ^{req_addr[0][DATA_WIDTH-1:LA_W], req_addr[1][DATA_WIDTH-1:LA_W]};

  // Round-robin: on a tie the port not granted last wins.
  assign w_any    = req_valid[0] | req_valid[1];
  assign w_win    = (req_valid[0] && req_valid[1]) ? ~r_last_grant : req_valid[1];
  assign w_accept = (r_state == ST_IDLE) && w_any && !rst;
  assign w_we     = req_we[w_win];
  assign w_size   = req_size[w_win];
  assign w_misal  = is_misaligned(w_size, req_addr[w_win][1:0]);

  dmem_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .i_size       (r_size),
    .i_addr_lo    (r_addr[1:0]),
    .i_unsigned   (r_unsigned),
    .i_rdata      (mem_rdata),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_data (w_store_data)
  );

  // FSM, grant history and request latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_err        <= 1'b0;
      r_unsigned   <= 1'b0;
      r_size       <= 2'b00;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_last_grant <= w_win;
            r_port       <= w_win;
            r_err        <= w_misal;
            r_unsigned   <= req_unsigned[w_win];
            r_size       <= w_size;
            r_addr       <= req_addr[w_win][LA_W-1:0];
            r_wdata      <= req_wdata[w_win];
            if (w_misal)                r_state <= ST_ACK;
            else if (!w_we)             r_state <= ST_LOAD;
            else if (w_size == SZ_WORD) r_state <= ST_ACK;
            else                        r_state <= ST_RMW;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake, memory and response drive; everything held low during reset.
  always_comb begin
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      req_ready[p]  = 1'b0;
      resp_valid[p] = 1'b0;
      resp_err[p]   = 1'b0;
      resp_rdata[p] = '0;
    end
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            req_ready[w_win] = 1'b1;
            if (!w_misal) begin
              mem_addr = DATA_WIDTH'(req_addr[w_win][LA_W-1:2]);
              if (w_we && (w_size == SZ_WORD)) begin
                mem_wen   = 1'b1;
                mem_wdata = req_wdata[w_win];
              end
            end
          end
        end
        ST_LOAD: begin
          resp_valid[r_port] = 1'b1;
          resp_rdata[r_port] = w_load_data;
        end
        ST_RMW: begin
          mem_wen            = 1'b1;
          mem_addr           = DATA_WIDTH'(r_addr[LA_W-1:2]);
          mem_wdata          = w_store_data;
          resp_valid[r_port] = 1'b1;
        end
        default: begin
          resp_valid[r_port] = 1'b1;
          resp_err[r_port]   = r_err;
        end
      endcase
    end
  end

endmodule
